// File: rtl/mc_control_fsm_if.sv
// -----------------------------------------------------------------------------
// mc_control_fsm_if
// Bundle between the multicycle main control unit and the MIPS-32 datapath.
//
// master modport (control unit side):
//   inputs  : opcode[5:0] (instr[31:26]), zero (ALU zero flag),
//             mem_ready (memory completes access this cycle)
//   outputs : iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
//             reg_write, alu_src_a, alu_src_b[1:0], pc_src[1:0], pc_en,
//             aluop[2:0], illegal, state[3:0]
// slave modport (datapath side): the same signals with directions reversed.
// -----------------------------------------------------------------------------
interface mc_control_fsm_if;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;

    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_en;
    logic [2:0] aluop;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  opcode, zero, mem_ready,
        output iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, pc_src, pc_en, aluop,
               illegal, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, pc_src, pc_en, aluop,
               illegal, state
    );
endinterface

// File: rtl/mc_control_fsm.sv
// -----------------------------------------------------------------------------
// mc_control_fsm
// Multicycle main control unit for the MIPS-32 core. Steps each instruction
// through fetch / decode / execute / memory / writeback states and produces
// the datapath enables plus the 3-bit ALU operation class.
//
// Ports:
//   clk  : system clock, all state updates on the rising edge
//   rst  : asynchronous active-high reset, forces FETCH immediately
//   bus  : mc_control_fsm_if.master
//          opcode/zero/mem_ready in; datapath enables, aluop, illegal and
//          the debug state code out.
//
// Outputs are a Moore decode of the state, except ir_write/pc_en in FETCH
// (qualified by mem_ready), pc_en in BRANCH (qualified by zero) and illegal
// in DECODE (decoded from the live opcode).
// -----------------------------------------------------------------------------
module mc_control_fsm #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic               clk,
    input  logic               rst,
    mc_control_fsm_if.master   bus
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_IMMEX  = 4'd9,
        S_IMMWB  = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_RTYPE = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b100;
    localparam logic [2:0] ALU_OR    = 3'b101;
    localparam logic [2:0] ALU_SLT   = 3'b110;

    state_t     cur_state;
    state_t     nxt_state;
    logic [5:0] op_lat;

    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_en;
    logic [2:0] aluop;
    logic       illegal;

    // ALU class for the immediate group; only reached with a valid imm opcode.
    function automatic logic [2:0] imm_aluop(input logic [5:0] op);
        logic [2:0] r;
        r = ALU_ADD;
        case (op)
            OP_ANDI: r = ALU_AND;
            OP_ORI:  r = ALU_OR;
            OP_SLTI: r = ALU_SLT;
            default: r = ALU_ADD;
        endcase
        return r;
    endfunction

    // State register and opcode latch. The opcode is captured on the DECODE
    // cycle so later states are immune to the instruction register changing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= state_t'(RESET_STATE);
            op_lat    <= '0;
        end else begin
            cur_state <= nxt_state;
            if (cur_state == S_DECODE) begin
                op_lat <= bus.opcode;
            end
        end
    end

    // Next-state and output decode.
    always_comb begin
        nxt_state  = S_FETCH;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        pc_en      = 1'b0;
        aluop      = ALU_ADD;
        illegal    = 1'b0;

        case (cur_state)
            S_FETCH: begin
                // PC + 4 computed while the instruction is read; the IR and
                // PC only commit on the cycle memory delivers.
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = bus.mem_ready;
                pc_en     = bus.mem_ready;
                nxt_state = bus.mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Branch target precompute: PC + (imm << 2).
                alu_src_b = 2'b11;
                case (bus.opcode)
                    OP_LW, OP_SW:                      nxt_state = S_MEMADR;
                    OP_RTYPE:                          nxt_state = S_EXEC;
                    OP_BEQ:                            nxt_state = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: nxt_state = S_IMMEX;
                    OP_J:                              nxt_state = S_JUMP;
                    default: begin
                        illegal   = 1'b1;
                        nxt_state = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                nxt_state = (op_lat == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord      = 1'b1;
                mem_read  = 1'b1;
                nxt_state = bus.mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                nxt_state  = S_FETCH;
            end
            S_MEMWR: begin
                // Strobe held for the full wait; memory takes it on mem_ready.
                iord      = 1'b1;
                mem_write = 1'b1;
                nxt_state = bus.mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                aluop     = ALU_RTYPE;
                nxt_state = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                nxt_state = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                aluop     = ALU_SUB;
                pc_src    = 2'b01;
                pc_en     = bus.zero;
                nxt_state = S_FETCH;
            end
            S_IMMEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                aluop     = imm_aluop(op_lat);
                nxt_state = S_IMMWB;
            end
            S_IMMWB: begin
                reg_write = 1'b1;
                nxt_state = S_FETCH;
            end
            S_JUMP: begin
                pc_src    = 2'b10;
                pc_en     = 1'b1;
                nxt_state = S_FETCH;
            end
            default: begin
                // Codes 12-15: all outputs stay 0, recover to FETCH.
                nxt_state = S_FETCH;
            end
        endcase
    end

    assign bus.iord       = iord;
    assign bus.mem_read   = mem_read;
    assign bus.mem_write  = mem_write;
    assign bus.ir_write   = ir_write;
    assign bus.reg_dst    = reg_dst;
    assign bus.mem_to_reg = mem_to_reg;
    assign bus.reg_write  = reg_write;
    assign bus.alu_src_a  = alu_src_a;
    assign bus.alu_src_b  = alu_src_b;
    assign bus.pc_src     = pc_src;
    assign bus.pc_en      = pc_en;
    assign bus.aluop      = aluop;
    assign bus.illegal    = illegal;
    assign bus.state      = cur_state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_mc_control_fsm
// Bench for mc_control_fsm. Each instruction is expanded by a reference model
// into a list of per-cycle stimulus and expected outputs (one record per
// clock), built from the instruction's class and its memory wait counts; the
// runner replays that list cycle by cycle and compares the whole output word.
// -----------------------------------------------------------------------------
module tb_mc_control_fsm;

    typedef struct packed {
        logic [3:0] st;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       pc_en;
        logic [2:0] aluop;
        logic       illegal;
    } cyc_t;

    typedef struct packed {
        logic [5:0] op;
        logic       mr;
        logic       z;
    } stim_t;

    logic clk;
    logic rst;
    int   n_total;
    int   n_pass;

    stim_t q_stim[$];
    cyc_t  q_exp[$];

    mc_control_fsm_if bus ();

    mc_control_fsm #(.RESET_STATE(4'd0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic cyc_t observed();
        cyc_t c;
        c.st         = bus.state;
        c.iord       = bus.iord;
        c.mem_read   = bus.mem_read;
        c.mem_write  = bus.mem_write;
        c.ir_write   = bus.ir_write;
        c.reg_dst    = bus.reg_dst;
        c.mem_to_reg = bus.mem_to_reg;
        c.reg_write  = bus.reg_write;
        c.alu_src_a  = bus.alu_src_a;
        c.alu_src_b  = bus.alu_src_b;
        c.pc_src     = bus.pc_src;
        c.pc_en      = bus.pc_en;
        c.aluop      = bus.aluop;
        c.illegal    = bus.illegal;
        return c;
    endfunction

    // ---------------- reference model ----------------
    // Instruction classes: 0 lw, 1 sw, 2 R-type, 3 beq, 4 imm, 5 j, 6 illegal
    function automatic int cls(input logic [5:0] op);
        case (op)
            6'b100011: return 0;
            6'b101011: return 1;
            6'b000000: return 2;
            6'b000100: return 3;
            6'b001000, 6'b001100, 6'b001101, 6'b001010: return 4;
            6'b000010: return 5;
            default:   return 6;
        endcase
    endfunction

    function automatic logic [2:0] imm_class(input logic [5:0] op);
        case (op)
            6'b001100: return 3'b100;
            6'b001101: return 3'b101;
            6'b001010: return 3'b110;
            default:   return 3'b000;
        endcase
    endfunction

    function automatic cyc_t blank(input logic [3:0] st);
        cyc_t c;
        c = '0;
        c.st = st;
        return c;
    endfunction

    function automatic cyc_t fetch_cyc(input logic mr);
        cyc_t c;
        c = blank(4'd0);
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
        c.ir_write  = mr;
        c.pc_en     = mr;
        return c;
    endfunction

    function automatic logic [5:0] rnd_op();
        return 6'($urandom_range(0, 63));
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic [5:0] op, input logic mr, input logic z, input cyc_t e);
        stim_t s;
        s.op = op;
        s.mr = mr;
        s.z  = z;
        q_stim.push_back(s);
        q_exp.push_back(e);
    endtask

    // Expand one instruction. fw/mw: wait cycles before mem_ready in fetch
    // and in the data-memory access. after_op < 0 drives random opcodes after
    // DECODE; otherwise that fixed value.
    task automatic build(input logic [5:0] op, input int fw, input int mw,
                         input logic z, input int after_op);
        cyc_t       c;
        logic [5:0] po;
        int         k;
        k = cls(op);
        for (int i = 0; i < fw; i++) push(rnd_op(), 1'b0, rbit(), fetch_cyc(1'b0));
        push(rnd_op(), 1'b1, rbit(), fetch_cyc(1'b1));
        c = blank(4'd1);
        c.alu_src_b = 2'b11;
        c.illegal   = (k == 6);
        push(op, rbit(), rbit(), c);
        po = (after_op < 0) ? rnd_op() : after_op[5:0];
        if (k == 0 || k == 1) begin
            c = blank(4'd2);
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
            push(po, rbit(), rbit(), c);
            c = (k == 0) ? blank(4'd3) : blank(4'd5);
            c.iord      = 1'b1;
            c.mem_read  = (k == 0);
            c.mem_write = (k == 1);
            for (int i = 0; i < mw; i++) push(po, 1'b0, rbit(), c);
            push(po, 1'b1, rbit(), c);
            if (k == 0) begin
                c = blank(4'd4);
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                push(po, rbit(), rbit(), c);
            end
        end else if (k == 2) begin
            c = blank(4'd6);
            c.alu_src_a = 1'b1;
            c.aluop     = 3'b010;
            push(po, rbit(), rbit(), c);
            c = blank(4'd7);
            c.reg_write = 1'b1;
            c.reg_dst   = 1'b1;
            push(po, rbit(), rbit(), c);
        end else if (k == 3) begin
            c = blank(4'd8);
            c.alu_src_a = 1'b1;
            c.aluop     = 3'b001;
            c.pc_src    = 2'b01;
            c.pc_en     = z;
            push(po, rbit(), z, c);
        end else if (k == 4) begin
            c = blank(4'd9);
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
            c.aluop     = imm_class(op);
            push(po, rbit(), rbit(), c);
            c = blank(4'd10);
            c.reg_write = 1'b1;
            push(po, rbit(), rbit(), c);
        end else if (k == 5) begin
            c = blank(4'd11);
            c.pc_src = 2'b10;
            c.pc_en  = 1'b1;
            push(po, rbit(), rbit(), c);
        end
    endtask

    // Replays the queued cycles: drive on the falling edge, check 1 time
    // unit later, let the rising edge advance the DUT.
    task automatic run_all(input string name);
        stim_t s;
        cyc_t  e;
        cyc_t  o;
        int    idx;
        idx = 0;
        while (q_exp.size() > 0) begin
            s = q_stim.pop_front();
            e = q_exp.pop_front();
            @(negedge clk);
            bus.opcode    = s.op;
            bus.mem_ready = s.mr;
            bus.zero      = s.z;
            #1;
            o = observed();
            chk($sformatf("%s_c%0d", name, idx), 32'(o), 32'(e));
            chk($sformatf("%s_excl%0d", name, idx),
                32'(bus.reg_write & bus.mem_write), 32'd0);
            idx++;
        end
    endtask

    task automatic expect_len(input string name, input int got, input int req);
        chk(name, got, req);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [5:0] legal [9];
        logic [5:0] op;
        int         len;
        legal = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000,
                  6'b001100, 6'b001101, 6'b001010, 6'b000010};
        n_total       = 0;
        n_pass        = 0;
        rst           = 1'b1;
        bus.opcode    = 6'b0;
        bus.mem_ready = 1'b0;
        bus.zero      = 1'b0;

        // Reset state: FETCH decode, ir_write/pc_en follow mem_ready.
        @(negedge clk);
        #1;
        chk("rst_mr0", 32'(observed()), 32'(fetch_cyc(1'b0)));
        bus.mem_ready = 1'b1;
        #1;
        chk("rst_mr1", 32'(observed()), 32'(fetch_cyc(1'b1)));
        @(negedge clk);
        chk("rst_hold_state", 32'(bus.state), 32'd0);
        bus.mem_ready = 1'b0;
        rst           = 1'b0;

        // lw with no waits: 5 cycles, states 0,1,2,3,4.
        build(6'b100011, 0, 0, 1'b0, 6'b100011);
        len = q_exp.size();
        expect_len("lw_latency", len, 5);
        run_all("lw");

        // R-type, 4 cycles.
        build(6'b000000, 0, 0, 1'b0, -1);
        expect_len("rtype_latency", q_exp.size(), 4);
        run_all("rtype");

        // beq taken, then not taken.
        build(6'b000100, 0, 0, 1'b1, -1);
        run_all("beq_z1");
        build(6'b000100, 0, 0, 1'b0, -1);
        run_all("beq_z0");

        // Immediate ops; opcode forced to 000000 after DECODE.
        build(6'b001100, 0, 0, 1'b0, 0);
        run_all("andi");
        build(6'b001101, 0, 0, 1'b0, 0);
        run_all("ori");
        build(6'b001010, 0, 0, 1'b0, 0);
        run_all("slti");
        build(6'b001000, 0, 0, 1'b0, 0);
        run_all("addi");

        // jump, then sw held 3 wait cycles (4 cycles in MEMWR).
        build(6'b000010, 0, 0, 1'b0, -1);
        run_all("j");
        build(6'b101011, 0, 3, 1'b0, 0);
        run_all("sw_wait");

        // Illegal opcode: 2 cycles, illegal pulse only in DECODE.
        build(6'b111111, 0, 0, 1'b0, -1);
        expect_len("ill_latency", q_exp.size(), 2);
        run_all("illegal");

        // sw reset mid-wait in MEMWR, asynchronously.
        push(rnd_op(), 1'b1, 1'b0, fetch_cyc(1'b1));
        begin
            cyc_t c;
            c = blank(4'd1);
            c.alu_src_b = 2'b11;
            push(6'b101011, 1'b1, 1'b0, c);
            c = blank(4'd2);
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
            push(6'b000000, 1'b1, 1'b0, c);
            c = blank(4'd5);
            c.iord      = 1'b1;
            c.mem_write = 1'b1;
            push(6'b000000, 1'b0, 1'b0, c);
            push(6'b000000, 1'b0, 1'b0, c);
        end
        run_all("sw_pre_rst");
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        chk("sw_still_wait", 32'(bus.state), 32'd5);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_state", 32'(bus.state), 32'd0);
        chk("async_rst_memwr", 32'(bus.mem_write), 32'd0);
        chk("async_rst_vec", 32'(observed()), 32'(fetch_cyc(1'b0)));
        @(negedge clk);
        rst = 1'b0;

        // Randomized instruction stream.
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) < 8) op = legal[$urandom_range(0, 8)];
            else op = rnd_op();
            build(op, $urandom_range(0, 2), $urandom_range(0, 3), rbit(), -1);
            run_all($sformatf("rnd%0d_op%02h", n, op));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Absolute time guard so the bench cannot hang.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "time limit");
    end

endmodule
